// File: rtl/enhance_auto_pkg.sv
// Shared definitions for the enhance datapath and its auto-exposure controller:
// HSV field positions, controller FSM encoding and the per-channel request decision.
package enhance_pkg;

  localparam int LAT_AUTO = 19;

  localparam int H_HI = 23;
  localparam int H_LO = 16;
  localparam int S_HI = 15;
  localparam int S_LO = 8;
  localparam int V_HI = 7;
  localparam int V_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    DIV_S,
    DIV_V,
    DECIDE
  } auto_state_e;

  typedef struct packed {
    logic inc;
    logic dec;
  } req_t;

  // Compared at 10 bits so target +/- band never wraps; inc and dec are exclusive.
  function automatic req_t decide(input logic [7:0] mean, input logic [9:0] target,
                                  input logic [9:0] band);
    req_t r;
    r.inc = ({2'b00, mean} + band) < target;
    r.dec = {2'b00, mean} > (target + band);
    return r;
  endfunction

endpackage

// File: rtl/enhance_auto_if.sv
// Pixel stream in, offset requests and frame statistics out, for the auto controller.
interface enhance_auto_if;

  logic        vsync;
  logic        auto_en;
  logic        pix_valid;
  logic [23:0] hsv_in;
  logic        inc_saturation;
  logic        dec_saturation;
  logic        inc_brightness;
  logic        dec_brightness;
  logic [7:0]  mean_s;
  logic [7:0]  mean_v;
  logic        busy;

  modport master (
    output vsync, auto_en, pix_valid, hsv_in,
    input  inc_saturation, dec_saturation, inc_brightness, dec_brightness,
    input  mean_s, mean_v, busy
  );

  modport slave (
    input  vsync, auto_en, pix_valid, hsv_in,
    output inc_saturation, dec_saturation, inc_brightness, dec_brightness,
    output mean_s, mean_v, busy
  );

endinterface

// File: rtl/enhance_auto_div.sv
// Restoring divider yielding an 8-bit quotient, one bit per cycle MSB first.
// done pulses 8 cycles after start; a new start aborts any division in flight.
module seq_div8 #(
  parameter int SUM_W = 28,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic [7:0]       quotient,
  output logic             done
);

  logic [SUM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [7:0]       quo_q, quo_d;
  logic [2:0]       k_q, k_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [SUM_W-1:0] shifted;

  // NOTE: every combinational output gets a default first, so no path leaves a latch.
  always_comb begin
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    k_d     = k_q;
    run_d   = run_q;
    done_d  = 1'b0;
    shifted = SUM_W'(div_q) << k_q;
    if (start) begin
      rem_d = dividend;
      div_d = divisor;
      quo_d = '0;
      k_d   = 3'd7;
      run_d = 1'b1;
    end else if (run_q) begin
      if (rem_q >= shifted) begin
        rem_d     = rem_q - shifted;
        quo_d[k_q] = 1'b1;
      end
      k_d = k_q - 3'd1;
      if (k_q == 3'd0) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // NOTE: state updates are non-blocking so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= '0;
      k_q    <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quo_q  <= quo_d;
      k_q    <= k_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/enhance_auto.sv
// Frame-mean auto controller: accumulates S/V per frame, divides at vsync fall and
// raises saturation/brightness offset requests that steer the means toward targets.
module enhance_auto
  import enhance_pkg::*;
#(
  parameter int SUM_W    = 28,
  parameter int CNT_W    = 20,
  parameter int S_TARGET = 128,
  parameter int V_TARGET = 128,
  parameter int DEADBAND = 8
) (
  input logic           clk,
  input logic           rst_n,
  enhance_auto_if.slave bus
);

  auto_state_e      state_q, state_d;
  logic             vsync_q;
  logic [SUM_W-1:0] sum_s_q, sum_s_d, sum_v_q, sum_v_d, hold_v_q, hold_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, hold_cnt_q, hold_cnt_d;
  logic [7:0]       quo_s_q, quo_s_d, quo_v_q, quo_v_d;
  logic [7:0]       mean_s_q, mean_s_d, mean_v_q, mean_v_d;
  req_t             s_req_q, s_req_d, v_req_q, v_req_d;

  logic             frame_edge;
  logic [7:0]       s_px, v_px;
  logic [SUM_W:0]   s_add, v_add;
  logic             div_start, div_done;
  logic [SUM_W-1:0] div_dividend;
  logic [CNT_W-1:0] div_divisor;
  logic [7:0]       div_quo;
  logic             unused_h;

  assign frame_edge = !bus.vsync && vsync_q;
  assign s_px       = bus.hsv_in[S_HI:S_LO];
  assign v_px       = bus.hsv_in[V_HI:V_LO];
  assign unused_h   = ^bus.hsv_in[H_HI:H_LO];
  assign s_add      = {1'b0, sum_s_q} + (SUM_W+1)'(s_px);
  assign v_add      = {1'b0, sum_v_q} + (SUM_W+1)'(v_px);

  // Live accumulators saturate instead of wrapping; a pixel in the edge cycle opens the new frame.
  always_comb begin
    sum_s_d = sum_s_q;
    sum_v_d = sum_v_q;
    cnt_d   = cnt_q;
    if (!bus.auto_en) begin
      sum_s_d = '0;
      sum_v_d = '0;
      cnt_d   = '0;
    end else if (frame_edge) begin
      sum_s_d = bus.pix_valid ? SUM_W'(s_px) : '0;
      sum_v_d = bus.pix_valid ? SUM_W'(v_px) : '0;
      cnt_d   = bus.pix_valid ? CNT_W'(1) : '0;
    end else if (bus.pix_valid) begin
      sum_s_d = s_add[SUM_W] ? '1 : s_add[SUM_W-1:0];
      sum_v_d = v_add[SUM_W] ? '1 : v_add[SUM_W-1:0];
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_v_d     = hold_v_q;
    hold_cnt_d   = hold_cnt_q;
    quo_s_d      = quo_s_q;
    quo_v_d      = quo_v_q;
    mean_s_d     = mean_s_q;
    mean_v_d     = mean_v_q;
    s_req_d      = s_req_q;
    v_req_d      = v_req_q;
    div_start    = 1'b0;
    div_dividend = sum_s_q;
    div_divisor  = cnt_q;
    if (!bus.auto_en) begin
      state_d = IDLE;
      s_req_d = '0;
      v_req_d = '0;
    end else if (frame_edge) begin
      // S goes straight from the live accumulator into the divider; V waits its turn.
      hold_v_d   = sum_v_q;
      hold_cnt_d = cnt_q;
      if (cnt_q == '0) begin
        state_d = IDLE;
        s_req_d = '0;
        v_req_d = '0;
      end else begin
        state_d   = DIV_S;
        div_start = 1'b1;
      end
    end else begin
      unique case (state_q)
        DIV_S: if (div_done) begin
          quo_s_d      = div_quo;
          div_start    = 1'b1;
          div_dividend = hold_v_q;
          div_divisor  = hold_cnt_q;
          state_d      = DIV_V;
        end
        DIV_V: if (div_done) begin
          quo_v_d = div_quo;
          state_d = DECIDE;
        end
        DECIDE: begin
          mean_s_d = quo_s_q;
          mean_v_d = quo_v_q;
          s_req_d  = decide(quo_s_q, 10'(S_TARGET), 10'(DEADBAND));
          v_req_d  = decide(quo_v_q, 10'(V_TARGET), 10'(DEADBAND));
          state_d  = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      sum_s_q    <= '0;
      sum_v_q    <= '0;
      cnt_q      <= '0;
      hold_v_q   <= '0;
      hold_cnt_q <= '0;
      quo_s_q    <= '0;
      quo_v_q    <= '0;
      mean_s_q   <= '0;
      mean_v_q   <= '0;
      s_req_q    <= '0;
      v_req_q    <= '0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= bus.vsync;
      sum_s_q    <= sum_s_d;
      sum_v_q    <= sum_v_d;
      cnt_q      <= cnt_d;
      hold_v_q   <= hold_v_d;
      hold_cnt_q <= hold_cnt_d;
      quo_s_q    <= quo_s_d;
      quo_v_q    <= quo_v_d;
      mean_s_q   <= mean_s_d;
      mean_v_q   <= mean_v_d;
      s_req_q    <= s_req_d;
      v_req_q    <= v_req_d;
    end
  end

  seq_div8 #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .done     (div_done)
  );

  assign bus.inc_saturation = s_req_q.inc;
  assign bus.dec_saturation = s_req_q.dec;
  assign bus.inc_brightness = v_req_q.inc;
  assign bus.dec_brightness = v_req_q.dec;
  assign bus.mean_s         = mean_s_q;
  assign bus.mean_v         = mean_v_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_enhance_auto.sv
// Scoreboard bench for enhance_auto: each frame's expected means/requests are queued
// at the vsync fall and compared when the result is due.
module tb_enhance_auto;

  typedef struct packed {
    logic       nz;
    logic [7:0] ms;
    logic [7:0] mv;
    logic [3:0] req;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   acc_s, acc_v, acc_n;
  exp_t last;
  exp_t sb[$];
  int   bvals[4] = '{136, 137, 119, 120};

  enhance_auto_if bus ();

  enhance_auto dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] reqs_now();
    return {bus.inc_saturation, bus.dec_saturation, bus.inc_brightness, bus.dec_brightness};
  endfunction

  // inc when mean + 8 < 128, dec when mean > 136
  function automatic logic [1:0] want(input int m);
    return {(m < 120), (m > 136)};
  endfunction

  task automatic drive_px(input int s, input int v, input bit valid);
    @(negedge clk);
    bus.pix_valid = valid;
    bus.hsv_in    = {8'($urandom), 8'(s), 8'(v)};
    if (valid) begin
      acc_s += s;
      acc_v += v;
      acc_n++;
    end
  endtask

  // Returns on the negedge where vsync falls; the following posedge closes the frame.
  task automatic end_frame();
    exp_t e;
    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.vsync     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.vsync = 1'b0;
    if (acc_n == 0) begin
      e = '{nz: 1'b0, ms: last.ms, mv: last.mv, req: 4'b0000};
    end else begin
      e.nz  = 1'b1;
      e.ms  = 8'(acc_s / acc_n);
      e.mv  = 8'(acc_v / acc_n);
      e.req = {want(acc_s / acc_n), want(acc_v / acc_n)};
    end
    sb.push_back(e);
    acc_s = 0;
    acc_v = 0;
    acc_n = 0;
  endtask

  task automatic wait_result();
    exp_t e;
    bit   saw_busy;
    e = sb.pop_front();
    saw_busy = 1'b0;
    repeat (19) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1'b1;
    end
    if (e.nz) begin
      check("hold_mean_s", 32'(bus.mean_s), 32'(last.ms));
      check("hold_mean_v", 32'(bus.mean_v), 32'(last.mv));
      check("hold_req", 32'(reqs_now()), 32'(last.req));
      check("busy_before_update", 32'(bus.busy), 32'd1);
    end else begin
      check("busy_empty_frame", 32'(saw_busy), 32'd0);
    end
    @(negedge clk);
    check("mean_s", 32'(bus.mean_s), 32'(e.ms));
    check("mean_v", 32'(bus.mean_v), 32'(e.mv));
    check("req", 32'(reqs_now()), 32'(e.req));
    check("busy_after", 32'(bus.busy), 32'd0);
    check("inv_sat", 32'(bus.inc_saturation & bus.dec_saturation), 32'd0);
    check("inv_bri", 32'(bus.inc_brightness & bus.dec_brightness), 32'd0);
    last = e;
  endtask

  initial begin
    bus.vsync     = 1'b0;
    bus.auto_en   = 1'b0;
    bus.pix_valid = 1'b0;
    bus.hsv_in    = '0;
    last  = '0;
    acc_s = 0;
    acc_v = 0;
    acc_n = 0;

    repeat (2) @(negedge clk);
    check("rst_req", 32'(reqs_now()), 32'd0);
    check("rst_mean_s", 32'(bus.mean_s), 32'd0);
    check("rst_mean_v", 32'(bus.mean_v), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n       = 1'b1;
    bus.auto_en = 1'b1;

    for (int i = 0; i < 100; i++) drive_px(200, 60, 1'b1);
    end_frame();
    wait_result();

    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) drive_px(128, bvals[b], 1'b1);
      end_frame();
      wait_result();
    end

    // invalid pixels carry large values that must not leak into the means
    drive_px(100, 10, 1'b1);
    drive_px(7, 255, 1'b0);
    drive_px(101, 11, 1'b1);
    drive_px(9, 250, 1'b0);
    drive_px(103, 12, 1'b1);
    end_frame();
    wait_result();

    // short frame: second vsync fall lands during DIV_V and supersedes the first
    for (int i = 0; i < 20; i++) drive_px(40, 200, 1'b1);
    end_frame();
    repeat (5) @(negedge clk);
    drive_px(220, 130, 1'b1);
    drive_px(220, 130, 1'b1);
    end_frame();
    sb.delete(0);
    wait_result();

    for (int i = 0; i < 5; i++) drive_px(50, 50, 1'b0);
    end_frame();
    wait_result();

    for (int i = 0; i < 40; i++) drive_px(30, 250, 1'b1);
    end_frame();
    wait_result();
    for (int i = 0; i < 30; i++) drive_px(200, 60, 1'b1);
    end_frame();
    repeat (12) @(negedge clk);
    check("busy_in_div_v", 32'(bus.busy), 32'd1);
    bus.auto_en = 1'b0;
    @(negedge clk);
    check("disable_req", 32'(reqs_now()), 32'd0);
    check("disable_busy", 32'(bus.busy), 32'd0);
    check("disable_mean_s", 32'(bus.mean_s), 32'(last.ms));
    check("disable_mean_v", 32'(bus.mean_v), 32'(last.mv));
    repeat (25) @(negedge clk);
    check("aborted_mean_s", 32'(bus.mean_s), 32'(last.ms));
    check("aborted_req", 32'(reqs_now()), 32'd0);
    sb.delete(0);
    last.req = 4'b0000;
    bus.auto_en = 1'b1;
    for (int i = 0; i < 50; i++) drive_px(90, 180, 1'b1);
    end_frame();
    wait_result();

    for (int i = 0; i < 10; i++) drive_px(10, 10, 1'b1);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(reqs_now()), 32'd0);
    check("async_rst_mean_s", 32'(bus.mean_s), 32'd0);
    check("async_rst_mean_v", 32'(bus.mean_v), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc_s = 0;
    acc_v = 0;
    acc_n = 0;
    last  = '0;

    for (int f = 0; f < 1000; f++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int p = 0; p < n; p++)
        drive_px(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 $urandom_range(0, 3) != 0);
      end_frame();
      wait_result();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
